// File: rtl/bus6502_pkg.sv
// Register map, bit positions and constants shared by the 6502 bus timer.
package bus6502_pkg;

    typedef enum logic [2:0] {
        REG_CNT_LO = 3'd0,
        REG_CNT_HI = 3'd1,
        REG_CTRL   = 3'd2,
        REG_STATUS = 3'd3,
        REG_WDKICK = 3'd4,
        REG_WDTIME = 3'd5,
        REG_RSVD6  = 3'd6,
        REG_RSVD7  = 3'd7
    } reg_off_e;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQEN   = 2;
    localparam int CTRL_WDEN    = 3;

    localparam int STAT_TF  = 0;
    localparam int STAT_WDF = 1;

    localparam logic [7:0] WD_KICK = 8'h5A;

endpackage

// File: rtl/bus6502_downcnt.sv
// 16-bit down counter: load has priority over decrement.
module bus6502_downcnt (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ld,
    input  logic [15:0] i_ld_val,
    input  logic        i_en,
    output logic [15:0] o_q,
    output logic        o_zero
);

    logic [15:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 16'd0;
        end else if (i_ld) begin
            r_q <= i_ld_val;
        end else if (i_en) begin
            r_q <= r_q - 16'd1;
        end
    end

    assign o_q    = r_q;
    assign o_zero = (r_q == 16'd0);

endmodule

// File: rtl/bus6502_timer.sv
// Memory-mapped interval timer plus sticky watchdog on a 6502-style bus,
// with a configurable number of wait states per access.
module bus6502_timer #(
    parameter logic [15:0] BASE = 16'hD000,
    parameter int          WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  DO,
    input  logic        WE,
    output logic [7:0]  DI,
    output logic        RDY,
    output logic        IRQ,
    output logic        NMI
);
    import bus6502_pkg::*;

    localparam logic [1:0] LP_WAIT = 2'(WAIT);

    logic [1:0]  r_wcnt;
    logic [7:0]  r_llo, r_lhi, r_wdt, r_di;
    logic        r_en, r_os, r_ie, r_wden, r_tf, r_wdf;

    logic        w_sel, w_commit, w_wr;
    reg_off_e    w_off;
    logic        w_wr_lo, w_wr_hi, w_wr_ctrl, w_wr_stat, w_wr_kick, w_wr_wdt;
    logic [7:0]  w_rdata;
    logic [15:0] w_tm_q, w_tm_val, w_wd_q;
    logic        w_tm_zero, w_expire, w_tm_ld;
    logic        w_wd_zero, w_wd_ld, w_wd_run, w_wd_hit;
    logic        w_kick, w_wden_set, w_wdf_clr;

    assign w_sel    = (A[15:3] == BASE[15:3]);
    // RDY is forced high during reset so a stalled CPU is released.
    assign RDY      = !reset || !w_sel || (r_wcnt == LP_WAIT);
    assign w_commit = w_sel && RDY;
    assign w_wr     = w_commit && WE;
    assign w_off    = reg_off_e'(A[2:0]);

    assign w_wr_lo   = w_wr && (w_off == REG_CNT_LO);
    assign w_wr_hi   = w_wr && (w_off == REG_CNT_HI);
    assign w_wr_ctrl = w_wr && (w_off == REG_CTRL);
    assign w_wr_stat = w_wr && (w_off == REG_STATUS);
    assign w_wr_kick = w_wr && (w_off == REG_WDKICK);
    assign w_wr_wdt  = w_wr && (w_off == REG_WDTIME);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wcnt <= 2'd0;
        end else if (!w_sel || w_commit) begin
            r_wcnt <= 2'd0;
        end else if (r_wcnt < LP_WAIT) begin
            r_wcnt <= r_wcnt + 2'd1;
        end
    end

    assign w_expire = r_en && w_tm_zero;
    assign w_tm_ld  = w_wr_hi || w_expire;
    assign w_tm_val = w_wr_hi ? {DO, r_llo} : {r_lhi, r_llo};

    bus6502_downcnt u_timer (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_ld     (w_tm_ld),
        .i_ld_val (w_tm_val),
        .i_en     (r_en),
        .o_q      (w_tm_q),
        .o_zero   (w_tm_zero)
    );

    assign w_kick     = w_wr_kick && (DO == WD_KICK);
    assign w_wden_set = w_wr_ctrl && DO[CTRL_WDEN] && !r_wden;
    assign w_wdf_clr  = w_wr_stat && DO[STAT_WDF] && r_wdf;
    assign w_wd_ld    = w_kick || w_wden_set || w_wdf_clr;
    assign w_wd_run   = r_wden && !r_wdf;
    // WDF rises on the same edge the count reaches zero.
    assign w_wd_hit   = w_wd_run && !w_wd_ld &&
                        (w_wd_zero || (w_wd_q == 16'd1));

    bus6502_downcnt u_wdog (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .i_ld     (w_wd_ld),
        .i_ld_val ({r_wdt, 8'h00}),
        .i_en     (w_wd_run && !w_wd_zero),
        .o_q      (w_wd_q),
        .o_zero   (w_wd_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_llo  <= 8'h00;
            r_lhi  <= 8'h00;
            r_wdt  <= 8'hFF;
            r_en   <= 1'b0;
            r_os   <= 1'b0;
            r_ie   <= 1'b0;
            r_wden <= 1'b0;
            r_tf   <= 1'b0;
            r_wdf  <= 1'b0;
        end else begin
            if (w_wr_lo) r_llo <= DO;
            if (w_wr_hi) r_lhi <= DO;
            if (w_wr_wdt) r_wdt <= DO;
            if (w_wr_ctrl) begin
                r_en   <= DO[CTRL_EN];
                r_os   <= DO[CTRL_ONESHOT];
                r_ie   <= DO[CTRL_IRQEN];
                r_wden <= r_wden | DO[CTRL_WDEN];
            end else if (w_expire && r_os) begin
                r_en <= 1'b0;
            end
            if (w_expire) begin
                r_tf <= 1'b1;
            end else if (w_wr_stat && DO[STAT_TF]) begin
                r_tf <= 1'b0;
            end
            if (w_wd_hit) begin
                r_wdf <= 1'b1;
            end else if (w_wdf_clr) begin
                r_wdf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            REG_CNT_LO: w_rdata = w_tm_q[7:0];
            REG_CNT_HI: w_rdata = w_tm_q[15:8];
            REG_CTRL: begin
                w_rdata[CTRL_EN]      = r_en;
                w_rdata[CTRL_ONESHOT] = r_os;
                w_rdata[CTRL_IRQEN]   = r_ie;
                w_rdata[CTRL_WDEN]    = r_wden;
            end
            REG_STATUS: begin
                w_rdata[STAT_TF]  = r_tf;
                w_rdata[STAT_WDF] = r_wdf;
            end
            REG_WDTIME: w_rdata = r_wdt;
            default: w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_di <= 8'h00;
        end else begin
            r_di <= (w_commit && !WE) ? w_rdata : 8'h00;
        end
    end

    assign DI  = r_di;
    assign IRQ = r_tf && r_ie;
    assign NMI = r_wdf;

endmodule

// File: doc/bus6502_timer.md
BUS6502_TIMER -- requirements
Module: bus6502_timer

Interface
REQ-001 Parameter BASE, default 16'hD000, base address; block decodes BASE..BASE+7 (BASE[2:0] ignored).
REQ-002 Parameter WAIT, default 0, wait states per access, range 0..3.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 A  input  16  CPU address bus.
REQ-006 DO  input  8  CPU write data.
REQ-007 WE  input  1  CPU write enable, active-high.
REQ-008 DI  output  8  read data to CPU, registered.
REQ-009 RDY  output  1  ready to CPU; low stalls the CPU.
REQ-010 IRQ  output  1  timer interrupt, active-high level.
REQ-011 NMI  output  1  watchdog interrupt, active-high level.

Function
REQ-012 sel = (A[15:3] == BASE[15:3]); commit = sel && RDY.
REQ-013 wcnt, 2 bits: increments while sel && wcnt<WAIT; clears on commit or when !sel; RDY = !sel || (wcnt == WAIT).
REQ-014 Back-to-back accesses with A held in range: each commit is followed by WAIT stall cycles.
REQ-015 Write: register updates on the commit edge when WE=1.
REQ-016 Read: on the commit edge with WE=0, DI loads the addressed register; otherwise DI loads 8'h00; read data is valid the cycle after commit.
REQ-017 Register map (offset A[2:0]):
  0 CNT_LO: R counter[7:0]; W reload latch low.
  1 CNT_HI: R counter[15:8]; W counter <= {DO, latch_lo}, latch_hi <= DO.
  2 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQEN, bit3 WDEN; bits 7:4 read 0.
  3 STATUS: bit0 TF, bit1 WDF; write 1 to clear each bit.
  4 WDKICK: W 8'h5A reloads the watchdog; other values ignored; reads 0.
  5 WDTIME: R/W watchdog period, in units of 256 cycles.
  6,7: reads 0; writes ignored.
REQ-018 Timer: 16-bit down counter; decrements by 1 per cycle while EN=1.
REQ-019 Timer expiry is a cycle with EN=1 and counter==0: TF set; counter reloads {latch_hi, latch_lo}; if ONESHOT=1, EN clears.
REQ-020 A reload value of 0 with ONESHOT=0 expires every cycle.
REQ-021 A CNT_HI write in the same cycle as expiry takes priority for the counter value; TF is still set.
REQ-022 An expiry in the same cycle as a STATUS write-1-to-clear of TF leaves TF set.
REQ-023 IRQ = TF && IRQEN, combinational from registers.
REQ-024 Watchdog: 16-bit down counter; a CTRL write setting WDEN loads {WDTIME, 8'h00}.
REQ-025 WDEN is sticky: once set, software writes cannot clear it; only reset clears it.
REQ-026 The watchdog decrements while WDEN=1 and WDF=0; at 0 it sets WDF and holds.
REQ-027 A WDKICK write of 8'h5A reloads {WDTIME, 8'h00}; a kick coinciding with reaching 0 takes priority (WDF not set).
REQ-028 Clearing WDF reloads the watchdog and restarts counting.
REQ-029 NMI = WDF.

Reset
REQ-030 While reset=0, all registers clear: counter, latches, CTRL, TF, WDF, watchdog and wcnt = 0; WDTIME = 8'hFF.
REQ-031 While reset=0: DI = 8'h00, RDY = 1, IRQ = 0, NMI = 0.
REQ-032 Reset asserted mid-access or mid-stall aborts the access; no register write is committed.

Structure
REQ-033 Package bus6502_pkg holds register offsets, CTRL/STATUS bit indices and the kick constant 8'h5A.
REQ-034 One sub-module, bus6502_downcnt: 16-bit loadable down counter with enable and zero flag; instantiated twice (timer, watchdog).

Verification
REQ-035 WAIT=0: write 8'h10 to offset 0, 8'h00 to offset 1, 8'h05 to offset 2 -> TF and IRQ high exactly 17 cycles after the CTRL commit, then every 17 cycles.
REQ-036 WAIT=2, read offset 5 after reset -> RDY low for 2 cycles, commit on cycle 3, DI = 8'hFF the following cycle, DI = 8'h00 afterwards.
REQ-037 ONESHOT with reload 3 -> a single TF; EN reads 0 afterwards; writing 8'h01 to STATUS clears TF and IRQ.
REQ-038 WDTIME=1, WDEN set, no kick -> NMI high 256 cycles after the CTRL commit; writing CTRL=0 leaves WDEN=1.
REQ-039 Kick 8'h5A every 200 cycles -> NMI never asserts; a kick of 8'h5B is ignored and NMI fires.
REQ-040 Drive reset low during a WAIT stall of a write to offset 2 -> CTRL stays 0 and RDY=1 while reset is low.
